// File: rtl/barrel_shifter_arb_pkg.sv
// Shared types, width helpers and flat-bus field macro for the shared-shifter scheduler.
// Requester fields are packed back to back; field r lives at [r*w +: w].
`define BSA_FIELD(bus, idx, w) bus[(idx)*(w) +: (w)]

package barrel_shifter_arb_pkg;

  localparam int DEF_BW_DATA = 8;
  localparam int DEF_NUM_REQ = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

  function automatic int calc_bw_k(input int bw_data);
    return $clog2(bw_data);
  endfunction

  function automatic int calc_bw_id(input int num_req);
    return $clog2(num_req);
  endfunction

endpackage

// File: rtl/barrel_shifter_arb_rr_arbiter.sv
// Round-robin arbiter: first valid request at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter
  import barrel_shifter_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int BW_ID   = calc_bw_id(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [BW_ID-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [BW_ID-1:0]   grant_idx
);

  logic found;

  always_comb begin : search
    int               c;
    logic [BW_ID-1:0] cand;
    found     = 1'b0;
    grant_idx = '0;
    c         = 0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = int'(ptr) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      cand = BW_ID'(c);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // grant_idx is still meaningful when en is low; only the grant is gated
  always_comb begin
    grant = '0;
    if (found && en) grant = NUM_REQ'(1) << grant_idx;
  end

endmodule

// File: rtl/barrel_shifter_arb_shifter.sv
// Combinational logical barrel shifter shared by all requesters.
module barrel_shifter
  import barrel_shifter_arb_pkg::*;
#(
  parameter  int BW_DATA = DEF_BW_DATA,
  localparam int BW_K    = calc_bw_k(BW_DATA)
) (
  input  logic [BW_DATA-1:0] a,
  input  logic [BW_K-1:0]    k,
  input  logic               left,
  output logic [BW_DATA-1:0] y
);

  always_comb begin
    y = '0;
    if (left) y = a << k;
    else      y = a >> k;
  end

endmodule

// File: rtl/barrel_shifter_arb.sv
// Time-shares one barrel_shifter among NUM_REQ requesters with a one-entry result register.
module barrel_shifter_arb
  import barrel_shifter_arb_pkg::*;
#(
  parameter  int BW_DATA = DEF_BW_DATA,
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int BW_K    = calc_bw_k(BW_DATA),
  localparam int BW_ID   = calc_bw_id(NUM_REQ)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*BW_DATA-1:0] i_req_a,
  input  logic [NUM_REQ*BW_K-1:0]    i_req_k,
  input  logic [NUM_REQ-1:0]         i_req_left,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_rsp_valid,
  output logic [BW_DATA-1:0]         o_rsp_y,
  output logic [BW_ID-1:0]           o_rsp_id,
  input  logic                       i_rsp_ready
);

  rsp_state_e         state;
  logic [BW_ID-1:0]   ptr;
  logic [BW_ID-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               can_accept;
  logic               arb_en;
  logic               hs;
  logic [BW_DATA-1:0] sel_a;
  logic [BW_K-1:0]    sel_k;
  logic               sel_left;
  logic [BW_DATA-1:0] shift_y;

  assign o_rsp_valid = (state == ST_FULL);
  assign can_accept  = !o_rsp_valid || i_rsp_ready;
  // reset gates ready so no requester sees a handshake that will be discarded
  assign arb_en      = can_accept && !i_rst;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req      (i_req_valid),
    .ptr      (ptr),
    .en       (arb_en),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  assign o_req_ready = grant;
  assign hs          = |grant;

  assign sel_a    = `BSA_FIELD(i_req_a, grant_idx, BW_DATA);
  assign sel_k    = `BSA_FIELD(i_req_k, grant_idx, BW_K);
  assign sel_left = i_req_left[grant_idx];

  barrel_shifter #(
    .BW_DATA(BW_DATA)
  ) u_shift (
    .a   (sel_a),
    .k   (sel_k),
    .left(sel_left),
    .y   (shift_y)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_EMPTY;
      o_rsp_y  <= '0;
      o_rsp_id <= '0;
      ptr      <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (hs) state <= ST_FULL;
        end
        ST_FULL: begin
          if (!hs && i_rsp_ready) state <= ST_EMPTY;
        end
        default: state <= ST_EMPTY;
      endcase
      if (hs) begin
        o_rsp_y  <= shift_y;
        o_rsp_id <= grant_idx;
        ptr      <= (grant_idx == BW_ID'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_barrel_shifter_arb.sv
// Randomized and directed bench for barrel_shifter_arb against a behavioural scheduler model.
module tb_barrel_shifter_arb;

  localparam int BW_DATA = 8;
  localparam int NUM_REQ = 4;
  localparam int BW_K    = 3;
  localparam int BW_ID   = 2;

  logic                       i_clk = 1'b0;
  logic                       i_rst = 1'b1;
  logic [NUM_REQ-1:0]         i_req_valid = '0;
  logic [NUM_REQ*BW_DATA-1:0] i_req_a = '0;
  logic [NUM_REQ*BW_K-1:0]    i_req_k = '0;
  logic [NUM_REQ-1:0]         i_req_left = '0;
  logic [NUM_REQ-1:0]         o_req_ready;
  logic                       o_rsp_valid;
  logic [BW_DATA-1:0]         o_rsp_y;
  logic [BW_ID-1:0]           o_rsp_id;
  logic                       i_rsp_ready = 1'b0;

  barrel_shifter_arb #(
    .BW_DATA(BW_DATA),
    .NUM_REQ(NUM_REQ)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req_valid(i_req_valid),
    .i_req_a    (i_req_a),
    .i_req_k    (i_req_k),
    .i_req_left (i_req_left),
    .o_req_ready(o_req_ready),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_y    (o_rsp_y),
    .o_rsp_id   (o_rsp_id),
    .i_rsp_ready(i_rsp_ready)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  bit m_valid = 0;
  int m_y     = 0;
  int m_id    = 0;
  int m_ptr   = 0;

  logic [NUM_REQ-1:0] ready_seen;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_shift(input int a, input int k, input bit left);
    if (left) return (a * (1 << k)) % (1 << BW_DATA);
    return a / (1 << k);
  endfunction

  function automatic int model_grant(input bit rst, input bit rsp_rdy);
    int r;
    if (rst) return -1;
    if (m_valid && !rsp_rdy) return -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      r = (m_ptr + i) % NUM_REQ;
      if (i_req_valid[r]) return r;
    end
    return -1;
  endfunction

  task automatic set_req(input int r, input bit v, input int a, input int k, input bit left);
    i_req_valid[r]              = v;
    i_req_a[r*BW_DATA +: BW_DATA] = BW_DATA'(a);
    i_req_k[r*BW_K +: BW_K]     = BW_K'(k);
    i_req_left[r]               = left;
  endtask

  task automatic all_valid_random();
    for (int r = 0; r < NUM_REQ; r++)
      set_req(r, 1'b1, $urandom_range(255), $urandom_range(7), 1'($urandom_range(1)));
  endtask

  task automatic step(input bit rst, input bit rsp_rdy);
    int g;
    logic [NUM_REQ-1:0] er;
    @(negedge i_clk);
    i_rst       = rst;
    i_rsp_ready = rsp_rdy;
    #1;
    g  = model_grant(rst, rsp_rdy);
    er = (g >= 0) ? NUM_REQ'(1 << g) : '0;
    ready_seen = o_req_ready;
    check_val("req_ready", 32'(o_req_ready), 32'(er));
    @(posedge i_clk);
    if (rst) begin
      m_valid = 0; m_y = 0; m_id = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_y     = ref_shift(int'(i_req_a[g*BW_DATA +: BW_DATA]), int'(i_req_k[g*BW_K +: BW_K]),
                          i_req_left[g]);
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % NUM_REQ;
    end else if (rsp_rdy && m_valid) begin
      m_valid = 0;
    end
    #1;
    check_val("rsp_valid", 32'(o_rsp_valid), 32'(m_valid));
    check_val("rsp_y", 32'(o_rsp_y), 32'(m_y));
    check_val("rsp_id", 32'(o_rsp_id), 32'(m_id));
  endtask

  initial begin
    int exp_ids[5];
    logic [BW_DATA-1:0] held_y;
    logic [BW_ID-1:0]   held_id;

    // reset with every requester asking
    all_valid_random();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check_val("reset_valid", 32'(o_rsp_valid), 32'd0);
    check_val("reset_y", 32'(o_rsp_y), 32'd0);
    check_val("reset_id", 32'(o_rsp_id), 32'd0);
    check_val("reset_ready", 32'(ready_seen), 32'd0);

    // single requester, left then right shift
    for (int r = 0; r < NUM_REQ; r++) set_req(r, 1'b0, 0, 0, 1'b0);
    set_req(1, 1'b1, 8'h0F, 2, 1'b1);
    step(1'b0, 1'b1);
    check_val("single_ready", 32'(ready_seen), 32'b0010);
    check_val("single_y_left", 32'(o_rsp_y), 32'h3C);
    check_val("single_id", 32'(o_rsp_id), 32'd1);
    set_req(1, 1'b1, 8'hF0, 4, 1'b0);
    step(1'b0, 1'b1);
    check_val("single_y_right", 32'(o_rsp_y), 32'h0F);

    // full contention from a fresh pointer
    step(1'b1, 1'b1);
    exp_ids = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      all_valid_random();
      step(1'b0, 1'b1);
      check_val("contend_valid", 32'(o_rsp_valid), 32'd1);
      check_val("contend_id", 32'(o_rsp_id), 32'(exp_ids[i]));
    end

    // sparse: only 0 and 2 valid, pointer sits at 1
    for (int i = 0; i < 4; i++) begin
      all_valid_random();
      i_req_valid = 4'b0101;
      step(1'b0, 1'b1);
      check_val("sparse_id", 32'(o_rsp_id), (i % 2 == 0) ? 32'd2 : 32'd0);
    end

    // backpressure while FULL
    held_y  = o_rsp_y;
    held_id = o_rsp_id;
    for (int i = 0; i < 3; i++) begin
      all_valid_random();
      step(1'b0, 1'b0);
      check_val("bp_ready", 32'(ready_seen), 32'd0);
      check_val("bp_y_stable", 32'(o_rsp_y), 32'(held_y));
      check_val("bp_id_stable", 32'(o_rsp_id), 32'(held_id));
      check_val("bp_valid", 32'(o_rsp_valid), 32'd1);
    end
    all_valid_random();
    step(1'b0, 1'b1);
    check_val("bp_release_id", 32'(o_rsp_id), 32'd1);

    // reset with a pending result and ptr at 2
    all_valid_random();
    step(1'b1, 1'b0);
    check_val("midrst_valid", 32'(o_rsp_valid), 32'd0);
    all_valid_random();
    step(1'b0, 1'b1);
    check_val("midrst_first_id", 32'(o_rsp_id), 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < NUM_REQ; r++)
        set_req(r, 1'($urandom_range(1)), $urandom_range(255), $urandom_range(7),
                1'($urandom_range(1)));
      step(($urandom_range(39) == 0), ($urandom_range(3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_arb.md
# barrel_shifter_arb

Round-robin scheduler that time-shares one combinational `barrel_shifter` instance among `NUM_REQ` requesters. Each requester presents an operand, a shift amount and a direction over a valid/ready handshake. The block grants one requester per cycle, registers the shifter result together with the requester ID, and holds it in a one-entry output register until the consumer accepts it. It sits between multiple datapath clients and the single shared shifter.

## Interface
Parameters:
- `BW_DATA`, 8, operand/result width; forwarded to `barrel_shifter`
- `NUM_REQ`, 4, number of requesters; ≥2
- `BW_K`, derived `$clog2(BW_DATA)`, shift-amount width; not overridable
- `BW_ID`, derived `$clog2(NUM_REQ)`, requester ID width; not overridable

Ports:
- `i_clk`  in  1  clock; all state updates on rising edge
- `i_rst`  in  1  reset, synchronous, active-high
- `i_req_valid`  in  NUM_REQ  per-requester valid
- `i_req_a`  in  NUM_REQ*BW_DATA  operands, requester r at bits [r*BW_DATA +: BW_DATA]
- `i_req_k`  in  NUM_REQ*BW_K  shift amounts, same packing
- `i_req_left`  in  NUM_REQ  direction, 1 = left
- `o_req_ready`  out  NUM_REQ  one-hot or zero; high only for the granted requester
- `o_rsp_valid`  out  1  result register holds valid data
- `o_rsp_y`  out  BW_DATA  shifter result
- `o_rsp_id`  out  BW_ID  index of the requester that produced `o_rsp_y`
- `i_rsp_ready`  in  1  consumer accepts the result

## Operation
- `can_accept = !o_rsp_valid || i_rsp_ready`.
- Arbitration is round-robin. The search starts at pointer `ptr` and takes the first `r` (modulo NUM_REQ) with `i_req_valid[r]=1`. `grant` is one-hot or zero.
- `o_req_ready = grant & {NUM_REQ{can_accept}}`. Ready depends combinationally on valid and on `i_rsp_ready`; there is no path from ready back to valid.
- Handshake on requester r means `i_req_valid[r] && o_req_ready[r]`. On that edge:
  - `o_rsp_y` ← `barrel_shifter(i_req_a[r], i_req_k[r], i_req_left[r])`
  - `o_rsp_id` ← r
  - `o_rsp_valid` ← 1
  - `ptr` ← (r+1) mod NUM_REQ
- No handshake, and `i_rsp_ready && o_rsp_valid`: `o_rsp_valid` ← 0. `o_rsp_y` and `o_rsp_id` hold their last values.
- Backpressure (`o_rsp_valid && !i_rsp_ready`):
  - all `o_req_ready` are 0;
  - `o_rsp_*` stay stable;
  - `ptr` is unchanged.
- Simultaneous consume and grant in the same cycle: the new result replaces the old one with no bubble.
- Requesters that are not valid are skipped. `ptr` advances only on a handshake.
- The datapath uses the shared shifter only; the block performs no arithmetic of its own. `i_req_k` values ≥ BW_DATA cannot occur because the port width is `BW_K`.

## Timing
- Latency: handshake at edge N → `o_rsp_valid`=1 with result visible after edge N.
- Throughput: one result per cycle while `i_rsp_ready`=1.
- Reset values: `o_rsp_valid`=0, `o_rsp_y`=0, `o_rsp_id`=0, `ptr`=0. `o_req_ready` is 0 during reset because it is forced low while `i_rst`=1.
- Reset mid-operation: a pending result is discarded; the next cycle starts with `ptr`=0.
- State machine: two states, EMPTY (`o_rsp_valid`=0) and FULL.
  - EMPTY → FULL on handshake.
  - FULL → EMPTY on consume with no handshake.
  - FULL → FULL on backpressure, or on consume with handshake.

## Structure
- Shared package/header holds the derived width constants `BW_K` and `BW_ID`, plus the flat-bus index macros.
- Sub-module `rr_arbiter` (parameter `NUM_REQ`): inputs request vector, `ptr`, enable; outputs one-hot grant and the encoded index.
- One `barrel_shifter` instance is fed by a grant-indexed mux.
- The top level holds the result register and `ptr`.

## Test plan
- **Reset:** hold `i_rst` 2 cycles with all requests valid → `o_rsp_valid`=0, `o_rsp_y`=0, `o_rsp_id`=0, `o_req_ready`=0.
- **Single request:** req1 with a=8'h0F, k=2, left=1 → `o_req_ready`=4'b0010. Next cycle: `o_rsp_y`=8'h3C, `o_rsp_id`=1. Then req1 with a=8'hF0, k=4, left=0 → 8'h0F.
- **Full contention:** all four valid continuously, `i_rsp_ready`=1 → `o_rsp_id` sequence is 0, 1, 2, 3, 0, one per cycle, with no bubbles.
- **Sparse fairness:** only req0 and req2 valid continuously → IDs alternate 0, 2, 0, 2.
- **Backpressure:** `i_rsp_ready`=0 for 3 cycles while FULL → `o_rsp_*` are stable, `o_req_ready`=0, and the next grant after release follows the pre-stall `ptr`.
- **Reset mid-operation:** assert `i_rst` while `o_rsp_valid`=1 with `ptr`=2 → after the edge `o_rsp_valid`=0. The first grant after reset goes to req0 when all requests are valid.
